// File: rtl/memaccess_unit.sv
// rtl/memaccess_unit.sv - LC3 MemAccess-stage engine: direct/indirect data-memory sequencing with stall timeout
module memaccess_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  mem_state,
    input  logic        m_control,
    input  logic [15:0] m_addr,
    input  logic [15:0] m_data,
    output logic        dmem_en,
    output logic        dmem_rd,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    input  logic        dmem_ready,
    input  logic [15:0] data_dout,
    output logic [15:0] memout,
    output logic        resp_valid,
    output logic        resp_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_PTR  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Abort fires on the stalled cycle in which the count reaches TIMEOUT.
    localparam logic [9:0] LAST_WAIT = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic        err_q, err_d;
    logic        dmem_rd_q, dmem_rd_d;
    logic [15:0] dmem_addr_q, dmem_addr_d;
    logic [15:0] dmem_din_q, dmem_din_d;
    logic [15:0] memout_q, memout_d;
    logic [9:0]  cnt_q, cnt_d;

    assign req_ready  = (state_q == IDLE);
    assign dmem_en    = (state_q == RD_PTR) || (state_q == RD_DATA) || (state_q == WR_DATA);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign dmem_rd    = dmem_rd_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_din   = dmem_din_q;
    assign memout     = memout_q;

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        err_d       = err_q;
        dmem_rd_d   = dmem_rd_q;
        dmem_addr_d = dmem_addr_q;
        dmem_din_d  = dmem_din_q;
        memout_d    = memout_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid && (mem_state[0] == 1'b0)) begin
                    op_wr_d     = mem_state[1];
                    dmem_addr_d = m_addr;
                    dmem_din_d  = m_data;
                    cnt_d       = 10'd0;
                    // A pointer fetch is always a read, whatever the final op.
                    dmem_rd_d   = m_control | ~mem_state[1];
                    if (m_control) begin
                        state_d = RD_PTR;
                    end else if (mem_state[1]) begin
                        state_d = WR_DATA;
                    end else begin
                        state_d = RD_DATA;
                    end
                end
            end
            RD_PTR, RD_DATA, WR_DATA: begin
                if (dmem_ready) begin
                    cnt_d = 10'd0;
                    err_d = 1'b0;
                    if (state_q == RD_PTR) begin
                        dmem_addr_d = data_dout;
                        dmem_rd_d   = ~op_wr_q;
                        state_d     = op_wr_q ? WR_DATA : RD_DATA;
                    end else begin
                        if (state_q == RD_DATA) begin
                            memout_d = data_dout;
                        end
                        state_d = RESP;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_wr_q     <= 1'b0;
            err_q       <= 1'b0;
            dmem_rd_q   <= 1'b1;
            dmem_addr_q <= 16'h0000;
            dmem_din_q  <= 16'h0000;
            memout_q    <= 16'h0000;
            cnt_q       <= 10'd0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            err_q       <= err_d;
            dmem_rd_q   <= dmem_rd_d;
            dmem_addr_q <= dmem_addr_d;
            dmem_din_q  <= dmem_din_d;
            memout_q    <= memout_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_memaccess_unit.sv
// tb/tb_memaccess_unit.sv - directed self-checking bench for memaccess_unit with response scoreboard
module tb_memaccess_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  mem_state = 2'b01;
    logic        m_control = 1'b0;
    logic [15:0] m_addr = 16'h0000;
    logic [15:0] m_data = 16'h0000;
    logic        dmem_en;
    logic        dmem_rd;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_din;
    logic        dmem_ready;
    logic [15:0] data_dout;
    logic [15:0] memout;
    logic        resp_valid;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:65535];
    int          stall_n = 0;
    int          wait_cnt = 0;
    logic [16:0] sb [$];
    logic [16:0] sb_exp;

    memaccess_unit #(.TIMEOUT(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_state  (mem_state),
        .m_control  (m_control),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .dmem_en    (dmem_en),
        .dmem_rd    (dmem_rd),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_ready (dmem_ready),
        .data_dout  (data_dout),
        .memout     (memout),
        .resp_valid (resp_valid),
        .resp_err   (resp_err)
    );

    always #5 clock = ~clock;

    // Memory model: ready after stall_n waiting cycles of each access.
    assign dmem_ready = dmem_en && (wait_cnt >= stall_n);
    assign data_dout  = mem[dmem_addr];

    always @(posedge clock) begin
        if (dmem_en && dmem_ready && !dmem_rd) begin
            mem[dmem_addr] = dmem_din;
        end
        if (dmem_en && !dmem_ready) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL resp_unexpected observed=resp_valid expected=no_response");
            end else begin
                sb_exp = sb.pop_front();
                chk("resp_memout", memout, sb_exp[15:0]);
                chk("resp_err", 16'(resp_err), 16'(sb_exp[16]));
            end
        end
    end

    task automatic issue(input logic [1:0] st, input logic ctl, input logic [15:0] a, input logic [15:0] d);
        mem_state = st;
        m_control = ctl;
        m_addr    = a;
        m_data    = d;
        req_valid = 1'b1;
        chk("req_ready_at_accept", 16'(req_ready), 16'd1);
        @(negedge clock);
        req_valid = 1'b0;
        m_addr    = 16'hDEAD;
        m_data    = 16'hDEAD;
    endtask

    initial begin
        mem[16'h3010] = 16'hBEEF;
        mem[16'h3020] = 16'hCAFE;
        mem[16'h4000] = 16'h5123;
        mem[16'h2000] = 16'h2100;
        mem[16'h2100] = 16'h7777;
        mem[16'hFFFF] = 16'h1234;

        #1 reset = 1'b0;
        #1;
        chk("rst_req_ready", 16'(req_ready), 16'd1);
        chk("rst_dmem_en", 16'(dmem_en), 16'd0);
        chk("rst_dmem_rd", 16'(dmem_rd), 16'd1);
        chk("rst_dmem_addr", dmem_addr, 16'h0000);
        chk("rst_dmem_din", dmem_din, 16'h0000);
        chk("rst_memout", memout, 16'h0000);
        chk("rst_resp_valid", 16'(resp_valid), 16'd0);
        chk("rst_resp_err", 16'(resp_err), 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Direct read
        sb.push_back({1'b0, 16'hBEEF});
        issue(2'b00, 1'b0, 16'h3010, 16'h0000);
        chk("rd_en_t1", 16'(dmem_en), 16'd1);
        chk("rd_addr_t1", dmem_addr, 16'h3010);
        chk("rd_rd_t1", 16'(dmem_rd), 16'd1);
        @(negedge clock);
        chk("rd_resp_t2", 16'(resp_valid), 16'd1);
        chk("rd_ready_resp", 16'(req_ready), 16'd0);
        @(negedge clock);

        // Indirect store
        sb.push_back({1'b0, 16'hBEEF});
        issue(2'b10, 1'b1, 16'h4000, 16'h00A5);
        chk("sti_ptr_addr", dmem_addr, 16'h4000);
        chk("sti_ptr_rd", 16'(dmem_rd), 16'd1);
        @(negedge clock);
        chk("sti_wr_en", 16'(dmem_en), 16'd1);
        chk("sti_wr_addr", dmem_addr, 16'h5123);
        chk("sti_wr_rd", 16'(dmem_rd), 16'd0);
        chk("sti_wr_din", dmem_din, 16'h00A5);
        @(negedge clock);
        chk("sti_resp_t3", 16'(resp_valid), 16'd1);
        chk("sti_mem_written", mem[16'h5123], 16'h00A5);
        @(negedge clock);

        // Indirect load, three stall cycles per phase
        stall_n = 3;
        sb.push_back({1'b0, 16'h7777});
        issue(2'b00, 1'b1, 16'h2000, 16'h0000);
        for (int i = 1; i <= 8; i++) begin
            chk("ldi_stall_en", 16'(dmem_en), 16'd1);
            chk("ldi_stall_rd", 16'(dmem_rd), 16'd1);
            chk("ldi_stall_addr", dmem_addr, (i <= 4) ? 16'h2000 : 16'h2100);
            chk("ldi_no_early_resp", 16'(resp_valid), 16'd0);
            @(negedge clock);
        end
        chk("ldi_resp_t9", 16'(resp_valid), 16'd1);
        @(negedge clock);

        // Timeout: memory never ready
        stall_n = 1000;
        sb.push_back({1'b1, 16'h7777});
        issue(2'b00, 1'b0, 16'h0050, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            chk("to_en_held", 16'(dmem_en), 16'd1);
            chk("to_no_early_resp", 16'(resp_valid), 16'd0);
            @(negedge clock);
        end
        chk("to_resp_t5", 16'(resp_valid), 16'd1);
        chk("to_en_dropped", 16'(dmem_en), 16'd0);
        @(negedge clock);
        stall_n = 0;

        // Normal read of the top address after a timeout
        sb.push_back({1'b0, 16'h1234});
        issue(2'b00, 1'b0, 16'hFFFF, 16'h0000);
        chk("top_addr", dmem_addr, 16'hFFFF);
        @(negedge clock);
        chk("top_resp_t2", 16'(resp_valid), 16'd1);
        @(negedge clock);

        // No-op request
        issue(2'b11, 1'b0, 16'h1111, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chk("noop_en", 16'(dmem_en), 16'd0);
            chk("noop_resp", 16'(resp_valid), 16'd0);
            chk("noop_ready", 16'(req_ready), 16'd1);
            @(negedge clock);
        end

        // Back-to-back with req_valid held through the busy cycles
        sb.push_back({1'b0, 16'hBEEF});
        sb.push_back({1'b0, 16'hCAFE});
        mem_state = 2'b00;
        m_control = 1'b0;
        m_addr    = 16'h3010;
        req_valid = 1'b1;
        @(negedge clock);
        chk("b2b_first_addr", dmem_addr, 16'h3010);
        m_addr = 16'h3020;
        @(negedge clock);
        chk("b2b_first_resp", 16'(resp_valid), 16'd1);
        chk("b2b_busy_ready", 16'(req_ready), 16'd0);
        @(negedge clock);
        chk("b2b_ready_after_resp", 16'(req_ready), 16'd1);
        @(negedge clock);
        req_valid = 1'b0;
        chk("b2b_second_en", 16'(dmem_en), 16'd1);
        chk("b2b_second_addr", dmem_addr, 16'h3020);
        @(negedge clock);
        chk("b2b_second_resp", 16'(resp_valid), 16'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("b2b_no_double", 16'(dmem_en), 16'd0);
        end

        // Reset during a stalled data read
        stall_n = 1000;
        issue(2'b00, 1'b0, 16'h3010, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_en", 16'(dmem_en), 16'd0);
        chk("mid_rst_memout", memout, 16'h0000);
        chk("mid_rst_resp", 16'(resp_valid), 16'd0);
        chk("mid_rst_addr", dmem_addr, 16'h0000);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        stall_n = 0;
        @(negedge clock);
        chk("post_rst_ready", 16'(req_ready), 16'd1);
        chk("post_rst_resp", 16'(resp_valid), 16'd0);

        sb.push_back({1'b0, 16'hCAFE});
        issue(2'b00, 1'b0, 16'h3020, 16'h0000);
        @(negedge clock);
        chk("post_rst_read_resp", 16'(resp_valid), 16'd1);
        @(negedge clock);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memaccess_unit.md
Name: memaccess_unit

Overview:
- LC3 MemAccess-stage engine, on the responding end of the memaccess_in bus.
- Consumes the mem_state/m_control/m_addr/m_data request fields from the control/execute side.
- Sequences data-memory transactions over a ready-stalled memory port, including two-access indirect LDI/STI, and returns read data on memout.
- Sits between the pipeline controller and the data memory; data_dout is the memory read-return bus.

Parameters:
- TIMEOUT, 255: maximum stalled cycles per memory access before abort; legal range 1 to 1023.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request strobe from controller
- req_ready  out  1  unit can accept a request
- mem_state  in  2  00 read, 10 write, 01/11 no-op
- m_control  in  1  1 = indirect (LDI/STI), 0 = direct
- m_addr  in  16  direct address, or pointer address when indirect
- m_data  in  16  store data
- dmem_en  out  1  memory access request
- dmem_rd  out  1  1 read, 0 write (valid while dmem_en)
- dmem_addr  out  16  memory address
- dmem_din  out  16  memory write data
- dmem_ready  in  1  memory completes the access this cycle
- data_dout  in  16  memory read data, valid when dmem_en & dmem_ready & dmem_rd
- memout  out  16  last read result (held)
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: access timed out

Behaviour:
- Reset (reset=0, async): state IDLE. Outputs: req_ready=1, dmem_en=0, dmem_rd=1, dmem_addr=0, dmem_din=0, memout=0, resp_valid=0, resp_err=0. Wait counter=0. Any in-flight access is dropped immediately, with no response.
- States: IDLE, RD_PTR, RD_DATA, WR_DATA, RESP.
- IDLE: req_ready=1, dmem_en=0.
  - Accept occurs on req_valid & req_ready.
  - On accept, latch m_addr, m_data, op and indirect flag.
  - Next state: mem_state=00 with m_control=0 goes to RD_DATA; 00 with m_control=1 goes to RD_PTR; 10 with m_control=0 goes to WR_DATA; 10 with m_control=1 goes to RD_PTR.
  - mem_state 01/11: accepted, no access, no response, remain in IDLE.
- RD_PTR: dmem_en=1, dmem_rd=1, dmem_addr=latched m_addr.
  - On dmem_ready, latch data_dout as the effective address.
  - Then go to RD_DATA (read) or WR_DATA (write).
- RD_DATA: dmem_en=1, dmem_rd=1, dmem_addr=effective address.
  - On dmem_ready, memout<=data_dout (registered), then go to RESP.
- WR_DATA: dmem_en=1, dmem_rd=0, dmem_addr=effective address, dmem_din=latched m_data.
  - The write commits in the dmem_ready cycle, then go to RESP. memout is unchanged.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, dmem_en=0. Next state IDLE.
- Effective address equals m_addr when direct.
- dmem_addr/dmem_rd/dmem_din are registered and stable for the whole access, including stall cycles.
- Latency with dmem_ready tied high (T = accept cycle):
  - direct access: dmem_en in T+1, resp_valid in T+2
  - indirect access: pointer read in T+1, data access in T+2, resp_valid in T+3
  - next accept possible in the cycle after RESP
- Wait counter:
  - Clears on entry to each access state.
  - Increments each cycle with dmem_en & !dmem_ready.
  - When the count equals TIMEOUT with ready still low, abort: go to RESP with resp_err=1. memout is unchanged and any remaining indirect phase is skipped.
  - resp_err=0 on all other responses.
  - dmem_ready in the same cycle the count hits TIMEOUT counts as success.
- req_valid while not in IDLE is ignored; the requester holds it until req_ready.
- m_* inputs are sampled only at accept; later changes have no effect.
- dmem_ready while dmem_en=0 is ignored.
- Addresses 16-bit; no arithmetic on them; 0xFFFF is a legal address.

Test Plan:
- Direct read: mem_state=00, m_control=0, m_addr=0x3010, memory[0x3010]=0xBEEF, dmem_ready high. Expect dmem_addr=0x3010 with dmem_rd=1 at T+1; resp_valid with memout=0xBEEF at T+2; resp_err=0.
- Indirect store (STI): m_control=1, mem_state=10, m_addr=0x4000, memory[0x4000]=0x5123, m_data=0x00A5. Expect pointer read of 0x4000, then write 0x00A5 to 0x5123 with dmem_rd=0; resp_valid at T+3; memout unchanged.
- Stalls: LDI with dmem_ready low 3 cycles in each phase. Expect address/control held constant during each stall; resp_valid at T+9 with correct data.
- Timeout: TIMEOUT=4, direct read, dmem_ready never asserted. Expect dmem_en high 4 cycles, then resp_valid=1 with resp_err=1; memout keeps its previous value; next request accepted normally.
- Reset mid-operation: assert reset during RD_DATA stall. Expect dmem_en=0 and memout=0 immediately without a clock edge, no resp_valid, req_ready=1 after release.
- No-op and back-to-back: mem_state=11 produces no dmem_en and no response. Two consecutive direct reads: second accept occurs the cycle after the first RESP; req_valid held during busy is not double-accepted.
